// File: rtl/uart_rx_core.sv
// UART receive framer: start-of-frame from an external falling-edge pulse,
// mid-bit sampling, LSB-first data, one-cycle valid / frame-error strobes.
module uart_rx_core #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_negedge,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CPB_M1 = CW'(CPB - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 busy_q;

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_negedge) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            cnt_q <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            // A start bit that is high again at mid-bit was only a glitch.
            if (!rx) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CPB_M1) begin
            cnt_q     <= '0;
            shift_q   <= {rx, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + BW'(1);
            if (bit_idx_q == LAST_BIT) begin
              state_q <= STOP;
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == CPB_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (rx) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed and random frames scored
// against an event-level model (expected strobe cycle, kind and byte).
module tb_uart_rx_core;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  localparam int LAT  = HALF + 8 * CPB + CPB;
  localparam int DCPB = 434;
  localparam int DLAT = 217 + 8 * 434 + 434;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx, rx_negedge, rx2, neg2;
  logic [7:0] data_out, dout2;
  logic       dv, fe, busy, dv2, fe2, busy2;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int dv2_n = 0;
  int fe2_n = 0;
  int dv2_cyc = 0;
  int last_pc = 0;
  int b0;
  logic [7:0] model_last = 8'h00;

  int         act_cyc[$];
  int         act_kind[$];
  logic [7:0] act_data[$];
  int         exp_cyc[$];
  int         exp_kind[$];
  logic [7:0] exp_data[$];

  uart_rx_core #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_negedge(rx_negedge),
    .data_out(data_out), .data_valid(dv), .frame_error(fe), .busy(busy)
  );

  uart_rx_core u_def (
    .clk(clk), .rst(rst), .rx(rx2), .rx_negedge(neg2),
    .data_out(dout2), .data_valid(dv2), .frame_error(fe2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe (kind bit0 = valid, bit1 = frame error) mid-cycle.
  always @(negedge clk) begin
    if (dv || fe) begin
      act_cyc.push_back(cyc);
      act_kind.push_back({30'd0, fe, dv});
      act_data.push_back(data_out);
    end
    if (busy) busy_cnt++;
    if (dv2) begin
      dv2_n++;
      dv2_cyc = cyc;
    end
    if (fe2) fe2_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit sel, input logic r, input logic n);
    if (sel) begin
      rx2  = r;
      neg2 = n;
    end else begin
      rx         = r;
      rx_negedge = n;
    end
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, act_cyc.size(), exp_cyc.size());
    while (exp_cyc.size() > 0 && act_cyc.size() > 0) begin
      chk({tag, "_cycle"}, act_cyc.pop_front(), exp_cyc.pop_front());
      chk({tag, "_kind"}, act_kind.pop_front(), exp_kind.pop_front());
      chk({tag, "_data"}, {24'd0, act_data.pop_front()}, {24'd0, exp_data.pop_front()});
    end
    exp_cyc.delete(); exp_kind.delete(); exp_data.delete();
    act_cyc.delete(); act_kind.delete(); act_data.delete();
  endtask

  // One full frame: start, LSB-first data, stop, then `gap` idle clocks.
  task automatic send(input bit sel, input logic [7:0] b, input logic stop,
                      input bit inject, input int gap);
    int cpb;
    cpb = sel ? DCPB : CPB;
    set_line(sel, 1'b0, 1'b1);
    last_pc = cyc + 1;
    if (!sel) begin
      exp_cyc.push_back(last_pc + LAT);
      if (stop) begin
        model_last = b;
        exp_kind.push_back(1);
      end else begin
        exp_kind.push_back(2);
      end
      exp_data.push_back(model_last);
    end
    step();
    set_line(sel, 1'b0, 1'b0);
    repeat (cpb - 1) step();
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < cpb; j++) begin
        set_line(sel, b[i], (inject && (i == 3 || i == 6) && j == 5) ? 1'b1 : 1'b0);
        step();
      end
    end
    set_line(sel, stop, 1'b0);
    repeat (cpb) step();
    set_line(sel, 1'b1, 1'b0);
    repeat (gap) step();
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         rg;
    logic [7:0] rst_byte;
    rst = 1'b1;
    rx = 1'b1; rx_negedge = 1'b0; rx2 = 1'b1; neg2 = 1'b0;
    repeat (3) step();
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_valid", {31'd0, dv}, 32'd0);
    chk("rst_ferr", {31'd0, fe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (4) step();

    b0 = busy_cnt;
    send(1'b0, 8'hA5, 1'b1, 1'b0, 4);
    chk("a5_busy_len", busy_cnt - b0, LAT);
    check_events("a5");
    chk("a5_hold", {24'd0, data_out}, 32'h0000_00A5);

    send(1'b0, 8'h3C, 1'b0, 1'b0, 4);
    check_events("ferr");
    chk("ferr_hold", {24'd0, data_out}, 32'h0000_00A5);

    b0 = busy_cnt;
    set_line(1'b0, 1'b0, 1'b1);
    step();
    set_line(1'b0, 1'b0, 1'b0);
    step(); step();
    set_line(1'b0, 1'b1, 1'b0);
    repeat (20) step();
    chk("glitch_busy_len", busy_cnt - b0, HALF);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    check_events("glitch");
    chk("glitch_hold", {24'd0, data_out}, {24'd0, model_last});

    // Abort a frame after three data bits; reset clears everything at once.
    rst_byte = 8'b0000_0101;
    set_line(1'b0, 1'b0, 1'b1);
    step();
    set_line(1'b0, 1'b0, 1'b0);
    repeat (CPB - 1) step();
    for (int i = 0; i < 3; i++) begin
      set_line(1'b0, rst_byte[i], 1'b0);
      repeat (CPB) step();
    end
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_data", {24'd0, data_out}, 32'd0);
    chk("mid_rst_valid", {31'd0, dv}, 32'd0);
    chk("mid_rst_ferr", {31'd0, fe}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    model_last = 8'h00;
    step(); step();
    rst = 1'b0;
    set_line(1'b0, 1'b1, 1'b0);
    repeat (12 * CPB) step();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    check_events("post_rst");

    send(1'b0, 8'h00, 1'b1, 1'b1, 0);
    send(1'b0, 8'hFF, 1'b1, 1'b1, 6);
    check_events("b2b");
    chk("b2b_final", {24'd0, data_out}, 32'h0000_00FF);

    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      rg = $urandom_range(0, 12);
      send(1'b0, rb, rs, ($urandom_range(0, 1) == 1), rg);
    end
    repeat (2) step();
    check_events("rand");
    chk("rand_final", {24'd0, data_out}, {24'd0, model_last});

    send(1'b1, 8'h55, 1'b1, 1'b0, 5);
    chk("def_count", dv2_n, 1);
    chk("def_cycle", dv2_cyc, last_pc + DLAT);
    chk("def_data", {24'd0, dout2}, 32'h0000_0055);
    chk("def_ferr", fe2_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
